// File: rtl/instr_fetch_mem.sv
// Instruction memory between the PC register and decode: self-clears after reset,
// then serves one registered fetch per cycle and accepts program loads.
module instr_fetch_mem #(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 16,
    parameter int              DEPTH     = 64,
    parameter bit              BYTE_ADDR = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_fault,
    output logic              ready,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  clr_cnt_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [ADDR_W-1:0] fetch_idx_s;
    logic [ADDR_W-1:0] load_idx_s;
    logic              fetch_bad_s;
    logic              load_bad_s;
    logic              fetch_go_s;
    logic              load_go_s;

    function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        if (BYTE_ADDR) begin
            return addr >> 1;
        end else begin
            return addr;
        end
    endfunction

    // Out-of-range is a fault rather than a modulo wrap, so the full index is compared.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] idx;
        idx = word_idx(addr);
        return (BYTE_ADDR && addr[0]) || ({1'b0, idx} >= DEPTH_V);
    endfunction

    // Address decode and accept conditions for both ports.
    always_comb begin
        fetch_idx_s = word_idx(pc);
        load_idx_s  = word_idx(load_addr);
        fetch_bad_s = addr_bad(pc);
        load_bad_s  = addr_bad(load_addr);
        fetch_go_s  = fetch_req && ready && !stall;
        load_go_s   = load_en && ready && !load_bad_s;
    end

    // Memory array: clearing sweep during CLEAR, program loads once ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            // contents are rebuilt by the CLEAR sweep after release
        end else if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (load_go_s) begin
            mem_r[load_idx_s[CNT_W-1:0]] <= load_data;
        end else begin
            // no write this cycle
        end
    end

    // Clear-sequencing FSM, ready flag and load rejection pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ready     <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + 1'b1;
                    if (clr_cnt_r == LAST_IDX) begin
                        state_r <= ST_READY;
                        ready   <= 1'b1;
                    end else begin
                        ready   <= 1'b0;
                    end
                end
                ST_READY: begin
                    ready <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                    ready     <= 1'b0;
                end
            endcase
            load_err <= load_en && (!ready || load_bad_s);
        end
    end

    // Fetch output register; the read sees the pre-load word on a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (stall) begin
            // pipeline stalled: hold outputs, drop any request
        end else if (fetch_go_s) begin
            instr_valid <= 1'b1;
            fetch_fault <= fetch_bad_s;
            if (fetch_bad_s) begin
                instr <= NOP_WORD;
            end else begin
                instr <= mem_r[fetch_idx_s[CNT_W-1:0]];
            end
        end else begin
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: stimulus pushes expected fetch results,
// a negedge monitor pops and compares whenever a new output is presented.
module tb_instr_fetch_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        stall = 1'b0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        fetch_fault;
    logic        ready;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = 16'h0000;
    logic [15:0] load_data = 16'h0000;
    logic        load_err;

    typedef struct packed {
        logic [15:0] instr;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic        stall_q = 1'b0;
    logic        rst_q   = 1'b1;
    logic [15:0] hold_instr = 16'h0000;
    logic        hold_valid = 1'b0;
    logic        hold_fault = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_mem #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(64), .BYTE_ADDR(1'b1), .NOP_WORD(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc), .stall(stall),
        .instr(instr), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
        .ready(ready), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_err(load_err)
    );

    always @(posedge clk) begin
        stall_q <= stall;
        rst_q   <= rst;
    end

    // Scoreboard monitor: new outputs are popped and compared, stalled cycles must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            hold_instr = 16'h0000;
            hold_valid = 1'b0;
            hold_fault = 1'b0;
        end else if (stall_q) begin
            n_vec++;
            if (instr !== hold_instr || instr_valid !== hold_valid || fetch_fault !== hold_fault) begin
                n_err++;
                $display("FAIL stall_hold: got instr=%h valid=%b fault=%b, want instr=%h valid=%b fault=%b",
                         instr, instr_valid, fetch_fault, hold_instr, hold_valid, hold_fault);
            end
        end else if (instr_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_fetch: got instr=%h fault=%b, want no output", instr, fetch_fault);
            end else begin
                e = exp_q.pop_front();
                if (instr !== e.instr || fetch_fault !== e.fault) begin
                    n_err++;
                    $display("FAIL fetch_result: got instr=%h fault=%b, want instr=%h fault=%b",
                             instr, fetch_fault, e.instr, e.fault);
                end
                hold_instr = e.instr;
                hold_valid = 1'b1;
                hold_fault = e.fault;
            end
        end else begin
            hold_valid = 1'b0;
            hold_fault = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] a, input logic [15:0] ei, input logic ef);
        fetch_req = 1'b1;
        pc        = a;
        exp_q.push_back(exp_t'{instr: ei, fault: ef});
        step();
        fetch_req = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d, input logic exp_err);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
        chk("load_err", {31'd0, load_err}, {31'd0, exp_err});
    endtask

    initial begin
        // 1: reset, clearing sweep, first fetch of a cleared word
        repeat (3) step();
        chk("rst_instr", {16'd0, instr}, 32'h0000_0000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            chk("ready_after_clear", {31'd0, ready}, (k == 64) ? 32'd1 : 32'd0);
        end
        fetch(16'h0010, 16'h0000, 1'b0);

        // 2: loads then back-to-back fetches
        load(16'h0000, 16'hF120, 1'b0);
        load(16'h0002, 16'hF121, 1'b0);
        load(16'h0064, 16'hEFFF, 1'b0);
        fetch(16'h0000, 16'hF120, 1'b0);
        fetch(16'h0002, 16'hF121, 1'b0);
        fetch(16'h0064, 16'hEFFF, 1'b0);

        // 3: misaligned and out-of-range accesses, no aliasing onto index 0
        fetch(16'h0003, 16'h0000, 1'b1);
        fetch(16'h0080, 16'h0000, 1'b1);
        load(16'h0080, 16'h1111, 1'b1);
        step();
        chk("load_err_pulse", {31'd0, load_err}, 32'd0);
        fetch(16'h0000, 16'hF120, 1'b0);

        // 4: stall holds output and ignores requests
        fetch(16'h0000, 16'hF120, 1'b0);
        stall     = 1'b1;
        fetch_req = 1'b1;
        pc        = 16'h0002;
        repeat (4) step();
        stall = 1'b0;
        exp_q.push_back(exp_t'{instr: 16'hF121, fault: 1'b0});
        step();
        fetch_req = 1'b0;

        // 5: same-cycle load and fetch to one index reads the old word
        load_en   = 1'b1;
        load_addr = 16'h0004;
        load_data = 16'hABCD;
        fetch_req = 1'b1;
        pc        = 16'h0004;
        exp_q.push_back(exp_t'{instr: 16'h0000, fault: 1'b0});
        step();
        load_en   = 1'b0;
        fetch_req = 1'b0;
        fetch(16'h0004, 16'hABCD, 1'b0);
        step();
        chk("idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("idle_instr_hold", {16'd0, instr}, 32'h0000_ABCD);

        // 6: reset in READY drops a pending fetch; reset mid-CLEAR restarts the sweep
        rst       = 1'b1;
        fetch_req = 1'b1;
        pc        = 16'h0000;
        step();
        fetch_req = 1'b0;
        chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst2_instr", {16'd0, instr}, 32'h0000_0000);
        chk("rst2_ready", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (k == 40) begin
                load_en   = 1'b1;
                load_addr = 16'h0002;
                load_data = 16'h5A5A;
            end
            step();
            if (k == 40) begin
                load_en = 1'b0;
                chk("clear_load_err", {31'd0, load_err}, 32'd1);
            end
            chk("ready_after_reclear", {31'd0, ready}, (k == 64) ? 32'd1 : 32'd0);
        end
        fetch(16'h0002, 16'h0000, 1'b0);
        fetch(16'h0000, 16'h0000, 1'b0);
        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
